// File: rtl/alu24_pkg.sv
// alu24_pkg: shared definitions for the 24-bit ALU result path.
//   ALU_W        operand width; results are ALU_W+1 bits wide, and the MSB
//                holds the carry or borrow
//   OP_*         3-bit ALU select codes
//   alu_entry_t  buffered result plus the status flags derived at push time
//   make_entry   builds an entry from a select and a result
package alu24_pkg;

    localparam int ALU_W = 24;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_REM  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef struct packed {
        logic [2:0]     select;
        logic [ALU_W:0] result;
        logic           zero;
        logic           neg;
        logic           carry;
    } alu_entry_t;

    // The result MSB means carry or borrow only for add and subtract. For
    // every other op it is masked off.
    function automatic alu_entry_t make_entry(input logic [2:0]     sel,
                                              input logic [ALU_W:0] res);
        alu_entry_t e;
        e.select = sel;
        e.result = res;
        e.zero   = (res[ALU_W-1:0] == '0);
        e.neg    = res[ALU_W-1];
        e.carry  = ((sel == OP_ADD) || (sel == OP_SUB)) ? res[ALU_W] : 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock show-ahead FIFO that exposes its occupancy.
//   clock, reset       rising-edge clock; asynchronous active-low reset
//   in_valid/in_ready  write handshake; in_ready is !full
//   in_data            write data
//   out_valid/ready    read handshake; out_valid is !empty
//   out_data           head entry, or zero while the FIFO is empty
//   count              occupancy, 0..DEPTH
// Both flags come only from the registered count. As a result:
//   - a push into an empty FIFO appears on the next cycle;
//   - a pop while full frees a slot only on the next cycle.
module sync_fifo_fwft #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;
    // Gate the output with out_valid so that an empty or reset FIFO shows zeros.
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: out_data is masked until an entry is written.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: rtl/alu24_result_sink.sv
// alu24_result_sink: receiving end of the 24-bit ALU datapath.
//   clock, reset            rising-edge clock; asynchronous active-low reset
//   in_valid/in_ready       upstream handshake; in_ready is !full
//   in_select, in_result    op code and result (MSB is carry or borrow)
//   out_valid/out_ready     downstream handshake for the head entry
//   out_select, out_result  head op code and result (zero when empty)
//   out_zero/neg/carry      head flags, computed when the entry was pushed
//   count                   FIFO occupancy
//   proto_err, clear_err    sticky upstream-stability error and its clear
// DATA_W must equal alu24_pkg::ALU_W, because the stored entry layout is
// fixed by the package struct.
module alu24_result_sink
    import alu24_pkg::*;
#(
    parameter  int DATA_W = 24,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_select,
    input  logic [DATA_W:0]   in_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_select,
    output logic [DATA_W:0]   out_result,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_carry,
    output logic [CNT_W-1:0]  count,
    output logic              proto_err,
    input  logic              clear_err
);

    alu_entry_t in_entry, head;

    assign in_entry = make_entry(in_select, in_result);

    sync_fifo_fwft #(
        .WIDTH ($bits(alu_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head),
        .count     (count)
    );

    assign out_select = head.select;
    assign out_result = head.result;
    assign out_zero   = head.zero;
    assign out_neg    = head.neg;
    assign out_carry  = head.carry;

    // Stability checker. Once upstream is stalled, it must keep in_valid high
    // and keep its payload unchanged on the next cycle. The previous payload
    // is captured every cycle, and it is compared only when stall_q is set.
    logic              stall_q;
    logic [2:0]        prev_sel_q;
    logic [DATA_W:0]   prev_res_q;
    logic              proto_err_q, proto_err_d;
    logic              violation;

    assign violation = stall_q && (!in_valid ||
                                   (in_select != prev_sel_q) ||
                                   (in_result != prev_res_q));

    // If a set and a clear arrive in the same cycle, the set wins.
    always_comb begin
        proto_err_d = proto_err_q;
        if (violation)      proto_err_d = 1'b1;
        else if (clear_err) proto_err_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q     <= 1'b0;
            prev_sel_q  <= '0;
            prev_res_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            stall_q     <= in_valid && !in_ready;
            prev_sel_q  <= in_select;
            prev_res_q  <= in_result;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_alu24_result_sink.sv
// tb_alu24_result_sink: directed-vector bench for alu24_result_sink.
// Inputs are driven 1 ns after each rising edge. Outputs are checked at the
// same point, after the state has updated and before the next edge.
module tb_alu24_result_sink;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_select;
    logic [24:0] in_result;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_select;
    logic [24:0] out_result;
    logic        out_zero;
    logic        out_neg;
    logic        out_carry;
    logic [3:0]  count;
    logic        proto_err;
    logic        clear_err;

    int n_checks = 0;
    int n_errors = 0;

    alu24_result_sink dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_select  (in_select),
        .in_result  (in_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_select (out_select),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_carry  (out_carry),
        .count      (count),
        .proto_err  (proto_err),
        .clear_err  (clear_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_select = 3'd0;
        in_result = 25'd0;
        out_ready = 1'b0;
        clear_err = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single push, then pop
        in_valid = 1'b1; in_select = 3'b000; in_result = 25'h1EA6B07;
        tick();
        in_valid = 1'b0;
        chk("s_valid", 32'(out_valid), 32'd1);
        chk("s_result", 32'(out_result), 32'h1EA6B07);
        chk("s_select", 32'(out_select), 32'd0);
        chk("s_zero", 32'(out_zero), 32'd0);
        chk("s_neg", 32'(out_neg), 32'd1);
        chk("s_carry", 32'(out_carry), 32'd1);
        chk("s_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("s_count_pop", 32'(count), 32'd0);
        chk("s_valid_pop", 32'(out_valid), 32'd0);

        // Carry masking
        in_valid = 1'b1; in_select = 3'b001; in_result = 25'h0000005;
        tick();
        in_select = 3'b100; in_result = 25'h1000000;
        tick();
        in_valid = 1'b0;
        chk("m1_carry", 32'(out_carry), 32'd0);
        chk("m1_zero", 32'(out_zero), 32'd0);
        chk("m1_neg", 32'(out_neg), 32'd0);
        chk("m1_select", 32'(out_select), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("m2_carry", 32'(out_carry), 32'd0);
        chk("m2_zero", 32'(out_zero), 32'd1);
        chk("m2_result", 32'(out_result), 32'h1000000);
        chk("m2_select", 32'(out_select), 32'd4);
        tick();
        out_ready = 1'b0;
        chk("m_count", 32'(count), 32'd0);

        // Fill and order
        in_select = 3'b101;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_result = 25'(i);
            chk($sformatf("f_in_ready_%0d", i), 32'(in_ready), 32'd1);
            tick();
        end
        in_result = 25'd8;
        chk("f_full_ready", 32'(in_ready), 32'd0);
        chk("f_full_count", 32'(count), 32'd8);
        tick();
        chk("f_count_after9", 32'(count), 32'd8);
        // Upstream abandons a stalled request, which counts as a violation.
        in_valid = 1'b0;
        tick();
        chk("f_abandon_err", 32'(proto_err), 32'd1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("f_err_cleared", 32'(proto_err), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("f_valid_%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("f_order_%0d", i), 32'(out_result), 32'(i));
            if (i == 0) chk("f_ready_at_pop", 32'(in_ready), 32'd0);
            tick();
            if (i == 0) chk("f_ready_after_pop", 32'(in_ready), 32'd1);
        end
        out_ready = 1'b0;
        chk("f_drained", 32'(out_valid), 32'd0);

        // Concurrent push/pop at count=3
        in_select = 3'b110;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_result = 25'(32'h100 + k);
            tick();
        end
        chk("c_count_pre", 32'(count), 32'd3);
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            in_result = 25'(32'h103 + j);
            chk($sformatf("c_head_%0d", j), 32'(out_result), 32'h100 + 32'(j));
            tick();
            chk($sformatf("c_count_%0d", j), 32'(count), 32'd3);
        end
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("c_tail_%0d", j), 32'(out_result), 32'h10A + 32'(j));
            tick();
        end
        out_ready = 1'b0;
        chk("c_empty", 32'(count), 32'd0);

        // Protocol violation while stalled
        in_select = 3'b101;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_result = 25'(i);
            tick();
        end
        in_result = 25'h0F53586;
        tick();
        chk("p_stall_no_err", 32'(proto_err), 32'd0);
        in_result = 25'h0F53581;
        tick();
        chk("p_err_set", 32'(proto_err), 32'd1);
        repeat (5) tick();
        chk("p_err_sticky", 32'(proto_err), 32'd1);
        in_valid = 1'b0;
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("p_err_cleared", 32'(proto_err), 32'd0);
        // A set and a clear in the same cycle: the set wins.
        in_valid = 1'b1; in_result = 25'd1;
        tick();
        in_result = 25'd2; clear_err = 1'b1;
        tick();
        chk("p_set_wins", 32'(proto_err), 32'd1);
        in_valid = 1'b0;
        tick();
        tick();
        clear_err = 1'b0;
        chk("p_err_cleared2", 32'(proto_err), 32'd0);

        // Reset mid-operation with count=5
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        chk("r_count5", 32'(count), 32'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("r_valid_async", 32'(out_valid), 32'd0);
        chk("r_count_async", 32'(count), 32'd0);
        chk("r_result_async", 32'(out_result), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        in_valid = 1'b1; in_select = 3'b000; in_result = 25'h0ABCDEF;
        tick();
        in_valid = 1'b0;
        chk("r_valid_new", 32'(out_valid), 32'd1);
        chk("r_result_new", 32'(out_result), 32'h0ABCDEF);
        chk("r_neg_new", 32'(out_neg), 32'd1);
        chk("r_carry_new", 32'(out_carry), 32'd0);
        chk("r_count_new", 32'(count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu24_result_sink.md
Name: alu24_result_sink

Overview:
Receiving end of the 24-bit ALU datapath. Accepts tagged ALU results (25-bit result plus the 3-bit select that produced it) over a valid/ready handshake and buffers them in a small FIFO. Derives status flags per entry and presents them to a downstream consumer over a second valid/ready port. Monitors the upstream handshake for stability violations and reports them through a sticky error flag.

Parameters:
DATA_W, 24, operand width; result width is DATA_W+1
DEPTH, 8, FIFO entries; power of two, minimum 2
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  upstream result valid
in_ready  output  1  sink can accept; equals !full
in_select  input  3  ALU op code for the result
in_result  input  DATA_W+1  ALU result; MSB is carry/borrow
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head entry
out_select  output  3  head op code
out_result  output  DATA_W+1  head result
out_zero  output  1  head result[DATA_W-1:0]==0
out_neg  output  1  head result[DATA_W-1]
out_carry  output  1  head result[DATA_W] if select is 000 or 001, else 0
count  output  CNT_W  current occupancy, 0..DEPTH
proto_err  output  1  sticky upstream handshake violation
clear_err  input  1  synchronous clear of proto_err

Behaviour:
- Reset (reset=0, asynchronous): pointers=0, count=0, out_valid=0, in_ready=1 once reset is released, proto_err=0. All out_* data outputs read 0.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- FIFO is show-ahead. An entry pushed into an empty FIFO appears on out_* with out_valid=1 on the next cycle (1-cycle latency).
- out_* data is stable while out_valid && !out_ready.
- Flags are computed at push time and stored with the entry, which is 3+DATA_W+1+3 bits wide.
- Full (count==DEPTH): in_ready=0 and no push. A same-cycle pop does not re-enable in_ready until the next cycle, so there is no bypass.
- Empty (count==0): out_valid=0. A simultaneous push is not forwarded combinationally.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Full and empty are distinguished using count.
- Stability check. A stall is a registered condition set in any cycle with in_valid && !in_ready. In the cycle after a stall, proto_err is set if either of the following holds:
  - in_valid==0, or
  - in_select or in_result differs from its previous value.
- proto_err is sticky. clear_err=1 clears it. If a set and a clear occur in the same cycle, set wins.
- count updates on the same edge as the push/pop.
- Reset asserted mid-operation discards all entries immediately. out_valid drops asynchronously.

Decomposition:
- Package alu24_pkg holds:
  - ALU_W=24
  - select constants: OP_ADD=000, OP_SUB=001, OP_DIV=010, OP_REM=011, OP_AND=100, OP_OR=101, OP_XOR=110, OP_XNOR=111
  - a packed struct for an entry {select, result, zero, neg, carry}
- One sub-module, sync_fifo_fwft (parameterised width/depth, show-ahead, count output). The top level adds flag derivation and the protocol checker.

Test Plan:
- Single push: select=000, result=0x1EA6B07, then out_ready=1. Required next cycle: out_valid=1, out_result=0x1EA6B07, zero=0, neg=1, carry=1, count=1. Required after the pop: count=0, out_valid=0.
- Carry masking: push select=001 result=0x0000005, then select=100 result=0x1000000. Required for entry 1: carry=0, zero=0, neg=0. Required for entry 2: carry=0 even though the MSB is set, and zero=1.
- Fill and order: with out_ready=0, push 8 results 0..7 (select 101). Required: in_ready=0 and count=8 on the 9th attempt, which is not accepted. Then with out_ready=1, the 8 entries drain in order 0..7 and in_ready returns 1 the cycle after the first pop.
- Concurrent push/pop: at count=3, run 10 cycles of in_valid=1, out_ready=1. Required: count stays 3 and the output sequence matches the input sequence offset by 3.
- Protocol violation: fill the FIFO, hold in_valid=1 with result=0x0F53586, then change to 0x0F53581 while stalled. Required: proto_err=1 next cycle, still 1 after 5 cycles, cleared after clear_err=1.
- Reset mid-operation: with count=5, drive reset=0 asynchronously mid-cycle. Required: out_valid=0 and count=0 immediately. After release, a new push appears with 1-cycle latency.
